// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VGC video RAM responder:
//   - SHADOW ($C035) inhibit bit indices
//   - CPU write window base/limit offsets and the bank numbers that reach VRAM
//   - vram_wr_t : one queued CPU write {17-bit VRAM address, data byte}
//   - slot_state_t : video fetch slot sequencer states
//   - shadow_hit() : decides whether a CPU write lands in VRAM
// -----------------------------------------------------------------------------
package vram_pkg;

    localparam int unsigned SH_TXT1 = 0;
    localparam int unsigned SH_HGR1 = 1;
    localparam int unsigned SH_HGR2 = 2;
    localparam int unsigned SH_SHR  = 3;
    localparam int unsigned SH_TXT2 = 5;

    localparam logic [15:0] TXT1_BASE  = 16'h0400;
    localparam logic [15:0] TXT1_LIMIT = 16'h07FF;
    localparam logic [15:0] TXT2_BASE  = 16'h0800;
    localparam logic [15:0] TXT2_LIMIT = 16'h0BFF;
    localparam logic [15:0] HGR1_BASE  = 16'h2000;
    localparam logic [15:0] HGR1_LIMIT = 16'h3FFF;
    localparam logic [15:0] HGR2_BASE  = 16'h4000;
    localparam logic [15:0] HGR2_LIMIT = 16'h5FFF;
    localparam logic [15:0] SHR_BASE   = 16'h2000;
    localparam logic [15:0] SHR_LIMIT  = 16'h9FFF;

    localparam logic [7:0] BANK_00 = 8'h00;
    localparam logic [7:0] BANK_01 = 8'h01;
    localparam logic [7:0] BANK_E0 = 8'hE0;
    localparam logic [7:0] BANK_E1 = 8'hE1;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } vram_wr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2
    } slot_state_t;

    function automatic logic in_win(input logic [15:0] off,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (off >= lo) && (off <= hi);
    endfunction

    // Banks E0/E1 always write through; banks 00/01 only inside a
    // non-inhibited shadow window. SHR shadowing exists for bank 01 only.
    function automatic logic shadow_hit(input logic [7:0]  bank,
                                        input logic [15:0] off,
                                        input logic [7:0]  shadow);
        logic lo_win;
        logic hit;
        lo_win = (in_win(off, TXT1_BASE, TXT1_LIMIT) && !shadow[SH_TXT1]) ||
                 (in_win(off, TXT2_BASE, TXT2_LIMIT) && !shadow[SH_TXT2]) ||
                 (in_win(off, HGR1_BASE, HGR1_LIMIT) && !shadow[SH_HGR1]) ||
                 (in_win(off, HGR2_BASE, HGR2_LIMIT) && !shadow[SH_HGR2]);
        case (bank)
            BANK_E0, BANK_E1: hit = 1'b1;
            BANK_00:          hit = lo_win;
            BANK_01:          hit = lo_win ||
                                    (in_win(off, SHR_BASE, SHR_LIMIT) && !shadow[SH_SHR]);
            default:          hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// vram_wr_fifo
// DEPTH-entry FIFO of CPU writes waiting for a free VRAM slot.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : enqueue request (taken only while o_ready is high)
//   i_pop          : dequeue request (ignored while o_empty)
//   o_head         : oldest entry, valid while !o_empty
//   o_empty        : registered empty flag
//   o_ready        : registered not-full flag; low while in reset
// -----------------------------------------------------------------------------
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_push,
    input  vram_wr_t i_din,
    input  logic     i_pop,
    output vram_wr_t o_head,
    output logic     o_empty,
    output logic     o_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    vram_wr_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_ready;
    logic [AW:0]   w_count_nxt;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count, so a pop while full only
    // reopens the write port on the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_ready = r_ready;

endmodule

// File: rtl/vram_shadow_port.sv
// -----------------------------------------------------------------------------
// vram_shadow_port
// Responder side of the VGC video fetch interface; owns the 128 KB VRAM.
//   clk_vid, reset_n          : clock, asynchronous active-low reset
//   ce_pix, video_addr        : VGC fetch request (video_addr[16] = bank E1)
//   video_data                : fetched byte, registered, holds until next fetch
//   cpu_we/cpu_addr/cpu_din   : CPU byte write; cpu_wr_ready = accepted
//   SHADOW                    : $C035 inhibit bits (1 = inhibit)
//   mem_addr/mem_we/mem_din   : VRAM port; mem_dout has 1-cycle read latency
// Optional (macro VRAM_CPU_READ_EN): cpu_re, cpu_rd_valid, cpu_dout add a
// CPU read path that waits for the write FIFO to drain.
// -----------------------------------------------------------------------------
module vram_shadow_port
    import vram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CE_MIN     = 3
) (
    input  logic        clk_vid,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [22:0] video_addr,
    output logic [7:0]  video_data,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wr_ready,
    input  logic [7:0]  SHADOW,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout
`ifdef VRAM_CPU_READ_EN
    ,
    input  logic        cpu_re,
    output logic        cpu_rd_valid,
    output logic [7:0]  cpu_dout
`endif
);

    // The three-state slot cycle needs pixel enables at least 3 clocks apart.
    generate
        if (CE_MIN < 3) begin : g_ce_min_unsupported
        end
    endgenerate

    slot_state_t r_state;
    logic        r_ce_d;
    logic        r_vid_oor;
    logic        w_vid_oor;
    logic        w_rd_slot;
    logic        w_wr_slot;
    logic        w_push_req;
    logic        w_fifo_empty;
    vram_wr_t    w_push_data;
    vram_wr_t    w_head;

    assign w_vid_oor = |video_addr[22:17];
    // An out-of-range fetch gives its RD_ISSUE cycle away to the write path.
    assign w_rd_slot = (r_state == RD_ISSUE) && !w_vid_oor;
    assign w_wr_slot = !w_rd_slot && !w_fifo_empty;

    assign w_push_req       = cpu_we && shadow_hit(cpu_addr[23:16], cpu_addr[15:0], SHADOW);
    assign w_push_data.addr = cpu_addr[16:0];
    assign w_push_data.data = cpu_din;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (clk_vid),
        .i_rst_n (reset_n),
        .i_push  (w_push_req),
        .i_din   (w_push_data),
        .i_pop   (w_wr_slot),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_ready (cpu_wr_ready)
    );

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ce_d     <= 1'b0;
            r_vid_oor  <= 1'b0;
            video_data <= '0;
        end else begin
            r_ce_d <= ce_pix;
            case (r_state)
                IDLE: begin
                    if (r_ce_d) r_state <= RD_ISSUE;
                end
                RD_ISSUE: begin
                    r_vid_oor <= w_vid_oor;
                    r_state   <= RD_CAPT;
                end
                RD_CAPT: begin
                    video_data <= r_vid_oor ? '0 : mem_dout;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VRAM_CPU_READ_EN
    logic        r_rd_pend;
    logic        r_rd_capt;
    logic [16:0] r_rd_addr;
    logic        w_cpu_rd_issue;

    // A pending read takes the first free slot once all earlier writes landed.
    assign w_cpu_rd_issue = r_rd_pend && w_fifo_empty && !w_rd_slot;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_capt    <= 1'b0;
            r_rd_addr    <= '0;
            cpu_rd_valid <= 1'b0;
            cpu_dout     <= '0;
        end else begin
            r_rd_capt    <= w_cpu_rd_issue;
            cpu_rd_valid <= r_rd_capt;
            if (r_rd_capt) cpu_dout <= mem_dout;
            if (w_cpu_rd_issue) begin
                r_rd_pend <= 1'b0;
            end else if (cpu_re && !r_rd_pend && !r_rd_capt) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= cpu_addr[16:0];
            end
        end
    end
`endif

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_rd_slot) begin
            mem_addr = video_addr[16:0];
        end else if (w_wr_slot) begin
            mem_we   = 1'b1;
            mem_addr = w_head.addr;
            mem_din  = w_head.data;
        end
`ifdef VRAM_CPU_READ_EN
        else if (w_cpu_rd_issue) begin
            mem_addr = r_rd_addr;
        end
`endif
    end

endmodule

// File: tb/tb_vram_shadow_port.sv
// -----------------------------------------------------------------------------
// tb_vram_shadow_port
// Scoreboard bench for vram_shadow_port: drivers push expected VRAM writes and
// video bytes into queues; a negedge monitor pops and compares them, and also
// checks the write-slot and ready rules every cycle.
// -----------------------------------------------------------------------------
module tb_vram_shadow_port;

    localparam int DEPTH = 4;

    logic        clk_vid = 1'b0;
    logic        reset_n;
    logic        ce_pix;
    logic [22:0] video_addr;
    logic [7:0]  video_data;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_wr_ready;
    logic [7:0]  SHADOW;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;
`ifdef VRAM_CPU_READ_EN
    logic        cpu_re = 1'b0;
    logic        cpu_rd_valid;
    logic [7:0]  cpu_dout;
`endif

    always #5 clk_vid = ~clk_vid;

    vram_shadow_port #(
        .FIFO_DEPTH (DEPTH),
        .CE_MIN     (3)
    ) dut (
        .clk_vid      (clk_vid),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .video_addr   (video_addr),
        .video_data   (video_data),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_wr_ready (cpu_wr_ready),
        .SHADOW       (SHADOW),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
`ifdef VRAM_CPU_READ_EN
        ,
        .cpu_re       (cpu_re),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_dout     (cpu_dout)
`endif
    );

    // Synchronous single-port VRAM, one cycle read latency.
    logic [7:0] vram [0:131071];
    always @(posedge clk_vid) begin
        if (mem_we) vram[mem_addr] <= mem_din;
        mem_dout <= vram[mem_addr];
    end

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          deadline;
    } wexp_t;

    typedef struct {
        bit         chk;
        logic [7:0] val;
    } vexp_t;

    wexp_t wq[$];
    vexp_t vq[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int occ     = 0;
    bit mon_en    = 1'b0;
    bit saw_full  = 1'b0;
    bit oor_drain = 1'b0;
    bit tb_inwin  = 1'b0;
    logic ce1 = 1'b0, ce2 = 1'b0, ce3 = 1'b0, ce4 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag_fail(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no response (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk_vid) begin
        cyc <= cyc + 1;
        ce1 <= ce_pix;
        ce2 <= ce1;
        ce3 <= ce2;
        ce4 <= ce3;
    end

    // ce2: cycle of the video read issue; ce4: cycle video_data must be valid.
    always @(negedge clk_vid) begin : monitor
        logic  inrange;
        logic  exp_we;
        wexp_t e;
        vexp_t v;
        if (mon_en && reset_n) begin
            inrange = (video_addr[22:17] == 6'd0);
            exp_we  = (occ != 0) && !(ce2 && inrange);
            check("mem_we_slot", 32'(mem_we), 32'(exp_we));
            check("cpu_wr_ready", 32'(cpu_wr_ready), 32'(occ != DEPTH));
            if (ce2 && inrange) check("rd_issue_addr", 32'(mem_addr), 32'(video_addr[16:0]));
            if (ce2 && !inrange && mem_we) oor_drain = 1'b1;
            if (mem_we) begin
                if (wq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got addr %05h data %02h, expected no write (cycle %0d)",
                             mem_addr, mem_din, cyc);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_din), 32'(e.data));
                    check("wr_in_time", 32'(cyc <= e.deadline), 32'd1);
                end
            end
            if (cpu_we && cpu_wr_ready && tb_inwin) occ++;
            if (mem_we) occ--;
            if (!cpu_wr_ready) saw_full = 1'b1;
            if (ce4) begin
                if (vq.size() == 0) flag_fail("video_expect_queue");
                else begin
                    v = vq.pop_front();
                    if (v.chk) check("video_data", 32'(video_data), 32'(v.val));
                end
            end
        end
    end

    task automatic cpu_write(input logic [7:0] bank, input logic [15:0] off, input logic [7:0] d,
                             input bit inwin, input logic [16:0] eaddr, input int slack);
        int    guard;
        wexp_t e;
        cpu_addr = {bank, off};
        cpu_din  = d;
        cpu_we   = 1'b1;
        tb_inwin = inwin;
        guard    = 0;
        @(negedge clk_vid);
        while (!cpu_wr_ready && guard < 40) begin
            @(negedge clk_vid);
            guard++;
        end
        if (!cpu_wr_ready) flag_fail("cpu_wr_ready_wait");
        else if (inwin) begin
            e.addr = eaddr;
            e.data = d;
            e.deadline = cyc + slack;
            wq.push_back(e);
        end
        @(posedge clk_vid); #1;
        cpu_we   = 1'b0;
        tb_inwin = 1'b0;
    endtask

    task automatic ce_pulse(input logic [22:0] va, input bit chk, input logic [7:0] ev);
        vexp_t v;
        v.chk = chk;
        v.val = ev;
        vq.push_back(v);
        video_addr = va;
        ce_pix = 1'b1;
        @(posedge clk_vid); #1;
        ce_pix = 1'b0;
        repeat (2) begin @(posedge clk_vid); #1; end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((wq.size() != 0 || vq.size() != 0) && guard < 60) begin
            @(posedge clk_vid); #1;
            guard++;
        end
        if (guard >= 60) flag_fail("drain");
        repeat (2) begin @(posedge clk_vid); #1; end
    endtask

    typedef struct packed {
        logic [7:0]  sh;
        logic [7:0]  bank;
        logic [15:0] off;
        logic [7:0]  d;
        logic        inwin;
        logic [16:0] ea;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC] = '{
        '{8'h01, 8'h00, 16'h0400, 8'h11, 1'b0, 17'h00000},
        '{8'h01, 8'hE0, 16'h0400, 8'h7F, 1'b1, 17'h00400},
        '{8'h02, 8'h01, 16'h2000, 8'h5A, 1'b1, 17'h12000},
        '{8'h02, 8'h00, 16'h2000, 8'h33, 1'b0, 17'h00000},
        '{8'h00, 8'h00, 16'h07FF, 8'hA1, 1'b1, 17'h007FF},
        '{8'h00, 8'h00, 16'h03FF, 8'hA2, 1'b0, 17'h00000},
        '{8'h01, 8'h00, 16'h0BFF, 8'hA3, 1'b1, 17'h00BFF},
        '{8'h20, 8'h00, 16'h0800, 8'hA4, 1'b0, 17'h00000},
        '{8'h00, 8'h01, 16'h9FFF, 8'hA5, 1'b1, 17'h19FFF},
        '{8'h00, 8'h01, 16'hA000, 8'hA6, 1'b0, 17'h00000},
        '{8'h00, 8'h00, 16'h9FFF, 8'hA7, 1'b0, 17'h00000},
        '{8'h00, 8'h00, 16'h5FFF, 8'hA8, 1'b1, 17'h05FFF},
        '{8'h00, 8'h00, 16'h6000, 8'hA9, 1'b0, 17'h00000},
        '{8'h08, 8'h01, 16'h4000, 8'hAA, 1'b1, 17'h14000},
        '{8'h08, 8'h01, 16'h6000, 8'hAB, 1'b0, 17'h00000},
        '{8'h0E, 8'h01, 16'h2000, 8'hAC, 1'b0, 17'h00000},
        '{8'h00, 8'h02, 16'h0400, 8'hAD, 1'b0, 17'h00000},
        '{8'hFF, 8'hE1, 16'hFFFF, 8'hAE, 1'b1, 17'h1FFFF}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        ce_pix     = 1'b0;
        video_addr = '0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_din    = '0;
        SHADOW     = 8'h00;

        // Reset state
        repeat (5) @(posedge clk_vid);
        @(negedge clk_vid);
        check("rst_video_data", 32'(video_data), 32'h00);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cpu_wr_ready", 32'(cpu_wr_ready), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk_vid); #1;
        reset_n = 1'b1;
        @(posedge clk_vid);
        @(negedge clk_vid);
        check("post_rst_ready", 32'(cpu_wr_ready), 32'd1);
        check("post_rst_video", 32'(video_data), 32'h00);
        mon_en = 1'b1;
        @(posedge clk_vid); #1;

        // Basic write then fetch
        SHADOW = 8'h00;
        cpu_write(8'h00, 16'h0400, 8'hC1, 1'b1, 17'h00400, 3);
        wait_idle();
        ce_pulse(23'h000400, 1'b1, 8'hC1);
        wait_idle();

        // Shadow window decode table
        for (int i = 0; i < NVEC; i++) begin
            SHADOW = vecs[i].sh;
            cpu_write(vecs[i].bank, vecs[i].off, vecs[i].d, vecs[i].inwin, vecs[i].ea, 3);
            wait_idle();
        end
        ce_pulse(23'h012000, 1'b1, 8'h5A);
        wait_idle();

        // Six back-to-back writes against a 3-clock pixel enable
        SHADOW = 8'h00;
        fork
            begin repeat (6) ce_pulse(23'h000010, 1'b0, 8'h00); end
            begin
                for (int i = 0; i < 6; i++)
                    cpu_write(8'h00, 16'h0400 + 16'(i), 8'hD0 + 8'(i), 1'b1, 17'h00400 + 17'(i), 8);
            end
        join
        wait_idle();
        ce_pulse(23'h000400, 1'b1, 8'hD0);
        ce_pulse(23'h000403, 1'b1, 8'hD3);
        wait_idle();

        // Longer burst that fills the FIFO
        fork
            begin repeat (8) ce_pulse(23'h000020, 1'b0, 8'h00); end
            begin
                for (int i = 0; i < 16; i++)
                    cpu_write(8'h01, 16'h2000 + 16'(i), 8'h40 + 8'(i), 1'b1, 17'h12000 + 17'(i), 20);
            end
        join
        wait_idle();
        check("fifo_filled", 32'(saw_full), 32'd1);
        ce_pulse(23'h012005, 1'b1, 8'h45);
        wait_idle();

        // Out-of-range fetch: zero data, issue slot drains a write
        fork
            ce_pulse(23'h020000, 1'b1, 8'h00);
            begin
                @(posedge clk_vid); #1;
                cpu_write(8'hE0, 16'h1234, 8'hAB, 1'b1, 17'h01234, 3);
            end
        join
        wait_idle();
        check("oor_slot_drain", 32'(oor_drain), 32'd1);
        ce_pulse(23'h001234, 1'b1, 8'hAB);
        wait_idle();

        check("wr_queue_empty", 32'(wq.size()), 32'd0);
        check("fifo_occupancy_zero", 32'(occ), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
